// File: rtl/reach_search_ctrl.sv
// reach_search_ctrl: sequencer for a random-stimulus reachability search on a small
// FSM DUT. It loads the DUT to its initial state, drives the DUT's 1-bit input from a
// 16-bit Galois LFSR, and compares the DUT state with TARGET every cycle. The search
// ends as reached when the state matches, or as timeout when the cycle budget runs out.
//
// Optional feature: define STIM_TRACE_EN to keep the last 32 stimulus bits in a shift
// register. When STIM_TRACE_EN is not defined, stim_trace is tied to zero.
//
// Ports:
//   clock      in   1        single clock; all state changes on posedge
//   reset      in   1        synchronous, active-high
//   start      in   1        begin a search; only sampled in IDLE
//   dut_state  in   STATE_W  current DUT state (same clock domain, not registered)
//   dut_init   out  1        DUT loads an all-zero state on the next posedge
//   stim       out  1        DUT stimulus input; comes from the FSM state and the LFSR
//   busy       out  1        high in INIT and RUN
//   done       out  1        one-cycle pulse when the search ends
//   reached    out  1        sticky: the search ended on dut_state == TARGET
//   timeout    out  1        sticky: the search ended because the budget ran out
//   cycles     out  CNT_W    number of stimulus cycles applied; held after done
//   stim_trace out  32       last 32 stim bits, newest in bit 0 (zero without the trace)
module reach_search_ctrl #(
  parameter int unsigned          STATE_W    = 2,
  parameter logic [STATE_W-1:0]   TARGET     = STATE_W'(2'b11),
  parameter int unsigned          MAX_CYCLES = 100000,
  parameter int unsigned          CNT_W      = 17,
  parameter logic [15:0]          LFSR_SEED  = 16'hACE1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [STATE_W-1:0] dut_state,
  output logic               dut_init,
  output logic               stim,
  output logic               busy,
  output logic               done,
  output logic               reached,
  output logic               timeout,
  output logic [CNT_W-1:0]   cycles,
  output logic [31:0]        stim_trace
);

  localparam logic [15:0]      LFSR_MASK = 16'hB400;
  // A zero seed would lock the LFSR at zero, so it is replaced by 1.
  localparam logic [15:0]      SEED_EFF  = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_INIT = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] lfsr_q;
  logic [15:0] lfsr_next;
  logic        step;      // stimulus applied this cycle
  logic        hit;       // target seen this cycle
  logic        expire;    // budget exhausted this cycle
  logic        clear;     // new search accepted this cycle

  assign lfsr_next = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);
  assign clear     = (state_q == S_IDLE) && start;

  // Next-state logic and the stimulus/event strobes. Target is checked before budget.
  always_comb begin
    state_d = state_q;
    stim    = 1'b0;
    step    = 1'b0;
    hit     = 1'b0;
    expire  = 1'b0;
    case (state_q)
      S_IDLE: if (start) state_d = S_INIT;
      S_INIT: state_d = S_RUN;
      S_RUN: begin
        if (dut_state == TARGET) begin
          hit     = 1'b1;
          state_d = S_DONE;
        end else if (cycles == CNT_MAX) begin
          expire  = 1'b1;
          state_d = S_DONE;
        end else begin
          step = 1'b1;
          stim = lfsr_q[0];
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register, registered status outputs, LFSR and cycle counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      dut_init <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      reached  <= 1'b0;
      timeout  <= 1'b0;
      cycles   <= '0;
      lfsr_q   <= SEED_EFF;
    end else begin
      state_q  <= state_d;
      dut_init <= (state_d == S_INIT);
      busy     <= (state_d == S_INIT) || (state_d == S_RUN);
      done     <= (state_d == S_DONE);
      if (clear) begin
        reached <= 1'b0;
        timeout <= 1'b0;
        cycles  <= '0;
      end
      if (state_q == S_INIT) lfsr_q <= SEED_EFF;
      if (hit)    reached <= 1'b1;
      if (expire) timeout <= 1'b1;
      if (step) begin
        lfsr_q <= lfsr_next;
        cycles <= cycles + CNT_W'(1);
      end
    end
  end

`ifdef STIM_TRACE_EN
  logic [31:0] trace_q;

  // Shift history of applied stimulus bits, newest in bit 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      trace_q <= '0;
    end else if (clear) begin
      trace_q <= '0;
    end else if (step) begin
      trace_q <= {trace_q[30:0], stim};
    end
  end

  assign stim_trace = trace_q;
`else
  assign stim_trace = 32'h0;
`endif

endmodule

// File: tb/tb_reach_search_ctrl.sv
// Self-checking bench for reach_search_ctrl: table of searches on two toy DUTs with a
// scoreboard of expected results, plus hand sequences for TARGET=0 and reset mid-run.
module tb_reach_search_ctrl;

  typedef struct packed {
    logic        reached;
    logic        timeout;
    logic [16:0] cycles;
    logic [31:0] trace;
  } exp_t;

  typedef struct {
    bit   use_cnt;   // 1: 2-bit counter DUT, 0: toy FSM with unreachable target
    bit   hold;      // keep start high through RUN and DONE
    exp_t e;
  } vec_t;

  localparam int MAXC = 100;

  logic        clock, reset, start0, start1, sel_cnt;
  logic [1:0]  toy_q, cnt_q, cnt1_q, dstate0;
  logic        dut_init0, stim0, busy0, done0, reached0, timeout0;
  logic        dut_init1, stim1, busy1, done1, reached1, timeout1;
  logic [16:0] cycles0, cycles1;
  logic [31:0] trace0, trace1;

  int   total = 0;
  int   bad   = 0;
  int   init_cnt = 0;
  bit   stim1_seen = 0;
  bit   excl_bad = 0;
  exp_t sb[$];

  assign dstate0 = sel_cnt ? cnt_q : toy_q;

  reach_search_ctrl #(.STATE_W(2), .TARGET(2'b11), .MAX_CYCLES(MAXC), .CNT_W(17),
                      .LFSR_SEED(16'hACE1)) u0 (
    .clock(clock), .reset(reset), .start(start0), .dut_state(dstate0),
    .dut_init(dut_init0), .stim(stim0), .busy(busy0), .done(done0),
    .reached(reached0), .timeout(timeout0), .cycles(cycles0), .stim_trace(trace0));

  reach_search_ctrl #(.STATE_W(2), .TARGET(2'b00), .MAX_CYCLES(MAXC), .CNT_W(17),
                      .LFSR_SEED(16'hACE1)) u1 (
    .clock(clock), .reset(reset), .start(start1), .dut_state(cnt1_q),
    .dut_init(dut_init1), .stim(stim1), .busy(busy1), .done(done1),
    .reached(reached1), .timeout(timeout1), .cycles(cycles1), .stim_trace(trace1));

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [1:0] toy_next(input logic [1:0] s, input logic a);
    return {a & s[0] & s[1], ~(s[0] & s[1])};
  endfunction

  // Small DUTs driven by the controllers.
  always @(posedge clock) begin
    if (reset) begin
      toy_q  <= 2'b00;
      cnt_q  <= 2'b00;
      cnt1_q <= 2'b00;
    end else begin
      toy_q  <= dut_init0 ? 2'b00 : toy_next(toy_q, stim0);
      cnt_q  <= dut_init0 ? 2'b00 : cnt_q + {1'b0, stim0};
      cnt1_q <= dut_init1 ? 2'b00 : cnt1_q + {1'b0, stim1};
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference search: DUT starts at zero, target checked before each stimulus.
  task automatic model_run(input bit use_cnt, input logic [1:0] tgt, input int maxc,
                           output exp_t e);
    logic [1:0]  s;
    logic [15:0] l;
    logic [31:0] tr;
    logic        a;
    int          c;
    s = 2'b00; l = 16'hACE1; tr = 32'h0; c = 0;
    e = '0;
    for (int i = 0; i <= maxc + 1; i++) begin
      if (s == tgt) begin e.reached = 1'b1; break; end
      if (c == maxc) begin e.timeout = 1'b1; break; end
      a  = l[0];
      tr = {tr[30:0], a};
      s  = use_cnt ? s + {1'b0, a} : toy_next(s, a);
      l  = l[0] ? ({1'b0, l[15:1]} ^ 16'hB400) : {1'b0, l[15:1]};
      c++;
    end
    e.cycles = 17'(c);
`ifndef STIM_TRACE_EN
    e.trace = 32'h0;
`else
    e.trace = tr;
`endif
  endtask

  // Scoreboard side: pop and compare whenever u0 pulses done.
  always @(negedge clock) begin
    if (!reset) begin
      if (dut_init0) init_cnt++;
      if (stim1) stim1_seen = 1'b1;
      if ((reached0 && timeout0) || (reached1 && timeout1)) excl_bad = 1'b1;
      if (done0) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'(done0), 32'h0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_reached", 32'(reached0), 32'(e.reached));
          chk("sb_timeout", 32'(timeout0), 32'(e.timeout));
          chk("sb_cycles",  32'(cycles0),  32'(e.cycles));
          chk("sb_trace",   trace0,        e.trace);
          chk("sb_busy",    32'(busy0),    32'h0);
        end
      end
    end
  end

  // Drive one search on u0 from a negedge in IDLE; returns at the negedge after DONE.
  task automatic run_search(input vec_t v);
    bit seen;
    seen     = 1'b0;
    sel_cnt  = v.use_cnt;
    init_cnt = 0;
    sb.push_back(v.e);
    start0 = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      if (i == 0) begin
        chk("init_dut_init", 32'(dut_init0), 32'h1);
        chk("init_busy",     32'(busy0),     32'h1);
        chk("init_cleared",  {30'h0, reached0, timeout0}, 32'h0);
        chk("init_cycles",   32'(cycles0),   32'h0);
        if (!v.hold) start0 = 1'b0;
      end
      if (done0) begin seen = 1'b1; break; end
    end
    if (!seen) begin
      chk("done_timeout", 32'h0, 32'h1);
      void'(sb.pop_back());
    end
    @(negedge clock);
    start0 = 1'b0;
    chk("idle_busy",     32'(busy0),     32'h0);
    chk("idle_done",     32'(done0),     32'h0);
    chk("idle_dut_init", 32'(dut_init0), 32'h0);
    chk("init_once",     32'(init_cnt),  32'h1);
    chk("hold_reached",  32'(reached0),  32'(v.e.reached));
    chk("hold_cycles",   32'(cycles0),   32'(v.e.cycles));
  endtask

  vec_t vecs[5];

  initial begin
    bit seen40;
    reset = 1'b1; start0 = 1'b0; start1 = 1'b0; sel_cnt = 1'b0;

    vecs[0].use_cnt = 1'b0; vecs[0].hold = 1'b0;
    vecs[1].use_cnt = 1'b1; vecs[1].hold = 1'b0;
    vecs[2].use_cnt = 1'b1; vecs[2].hold = 1'b1;
    vecs[3].use_cnt = 1'b0; vecs[3].hold = 1'b1;
    vecs[4].use_cnt = 1'b1; vecs[4].hold = 1'b0;
    foreach (vecs[i]) model_run(vecs[i].use_cnt, 2'b11, MAXC, vecs[i].e);

    repeat (3) @(negedge clock);
    chk("rst_busy",     32'(busy0),     32'h0);
    chk("rst_done",     32'(done0),     32'h0);
    chk("rst_dut_init", 32'(dut_init0), 32'h0);
    chk("rst_stim",     32'(stim0),     32'h0);
    chk("rst_flags",    {30'h0, reached0, timeout0}, 32'h0);
    chk("rst_cycles",   32'(cycles0),   32'h0);
    chk("rst_trace",    trace0,         32'h0);
    reset = 1'b0;
    @(negedge clock);
    chk("idle_no_start", 32'(busy0), 32'h0);

    // Back-to-back searches: each new start lands in the IDLE cycle after DONE.
    for (int i = 0; i < 5; i++) run_search(vecs[i]);

    // TARGET = 0 on u1: reached in the first RUN cycle, no stimulus.
    start1 = 1'b1;
    @(negedge clock);
    start1 = 1'b0;
    chk("t0_init",   {30'h0, dut_init1, busy1}, 32'h3);
    @(negedge clock);
    chk("t0_run",    {29'h0, dut_init1, busy1, done1}, 32'h2);
    @(negedge clock);
    chk("t0_done",   32'(done1),    32'h1);
    chk("t0_reached",32'(reached1), 32'h1);
    chk("t0_timeout",32'(timeout1), 32'h0);
    chk("t0_cycles", 32'(cycles1),  32'h0);
    @(negedge clock);
    chk("t0_after",  {30'h0, busy1, done1}, 32'h0);
    chk("t0_stim_never", 32'(stim1_seen), 32'h0);
    chk("t0_trace",  trace1, 32'h0);

    // Reset in RUN at cycles=40 aborts immediately without a done pulse.
    sel_cnt = 1'b0;
    start0  = 1'b1;
    @(negedge clock);
    start0  = 1'b0;
    seen40  = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (cycles0 == 17'd40) begin seen40 = 1'b1; break; end
    end
    chk("reach_40", 32'(seen40), 32'h1);
    reset = 1'b1;
    @(negedge clock);
    chk("abort_outs", {26'h0, dut_init0, stim0, busy0, done0, reached0, timeout0}, 32'h0);
    chk("abort_cycles", 32'(cycles0), 32'h0);
    chk("abort_trace",  trace0,       32'h0);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("abort_no_done", {31'h0, done0}, 32'h0);
    chk("abort_idle",    32'(busy0), 32'h0);
    chk("sb_empty",      32'(sb.size()), 32'h0);
    chk("excl_flags",    32'(excl_bad), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
